// File: rtl/instruction_cache_pkg.sv
// instruction_cache_pkg: shared widths, FSM encoding and constants for the instruction cache.
package instruction_cache_pkg;
  localparam int WORD_W = 32;
  localparam int WORDS_PER_LINE = 4;
  localparam int LINE_W = WORD_W * WORDS_PER_LINE;
  localparam int LINE_ADDR_W = 28;
  localparam logic [31:0] NOP = 32'h00000013;
  typedef enum logic [1:0] {IDLE = 2'd0, MEM_READ = 2'd1, UPDATE = 2'd2} state_t;
endpackage

// File: rtl/instruction_cache_if.sv
// instruction_cache_if: line-fill bus between the instruction cache and instruction memory.
interface instruction_cache_if;
  import instruction_cache_pkg::*;
  logic mem_read;
  logic [LINE_ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_readdata;
  logic mem_busywait;
  modport master(output mem_read, mem_address, input mem_readdata, mem_busywait);
  modport slave(input mem_read, mem_address, output mem_readdata, mem_busywait);
endinterface

// File: rtl/icache_storage.sv
// icache_storage: valid/tag/data arrays with combinational lookup and synchronous line write / invalidate-all.
module icache_storage import instruction_cache_pkg::*; #(
  parameter int NUM_LINES = 8,
  parameter int IDX = $clog2(NUM_LINES),
  parameter int TAG_W = LINE_ADDR_W - IDX
) (
  input  logic clock,
  input  logic reset,
  input  logic [IDX-1:0] index,
  input  logic [TAG_W-1:0] tag,
  input  logic [1:0] offset,
  output logic hit,
  output logic [WORD_W-1:0] instruction,
  input  logic write_en,
  input  logic [IDX-1:0] write_index,
  input  logic [TAG_W-1:0] write_tag,
  input  logic [LINE_W-1:0] write_data,
  input  logic invalidate
);
  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0] tags [NUM_LINES];
  logic [LINE_W-1:0] data [NUM_LINES];
  assign hit = valid[index] && tags[index] == tag;
  assign instruction = data[index][WORD_W*offset +: WORD_W];
  always_ff @(posedge clock or posedge reset)
    if (reset) valid <= '0;
    else if (invalidate) valid <= '0;
    else if (write_en) valid[write_index] <= 1'b1;
  // tags and data carry no reset; valid alone guards them
  always_ff @(posedge clock)
    if (write_en) begin
      tags[write_index] <= write_tag;
      data[write_index] <= write_data;
    end
endmodule

// File: rtl/instruction_cache.sv
// instruction_cache: direct-mapped read-only I-cache with fill FSM, flush-all and saturating hit/miss counters.
module instruction_cache import instruction_cache_pkg::*; #(
  parameter int NUM_LINES = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic [31:0] address,
  output logic [31:0] instruction,
  output logic busywait,
  input  logic flush,
  input  logic counter_clear,
  instruction_cache_if.master mem,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int IDX = $clog2(NUM_LINES);
  localparam int TAG_W = LINE_ADDR_W - IDX;
  state_t state, next_state;
  logic flush_pending, hit, flushing, hit_event, miss_event, unused_bits;
  logic [LINE_W-1:0] line;
  logic [31:0] hit_total, miss_total;
  assign unused_bits = ^address[1:0];
  icache_storage #(.NUM_LINES(NUM_LINES)) storage (
    .clock, .reset,
    .index(address[4 +: IDX]), .tag(address[31 -: TAG_W]), .offset(address[3:2]),
    .hit, .instruction,
    .write_en(state == UPDATE),
    .write_index(mem.mem_address[IDX-1:0]),
    .write_tag(mem.mem_address[LINE_ADDR_W-1 -: TAG_W]),
    .write_data(line),
    .invalidate(flushing)
  );
  assign flushing = state == IDLE && (flush || flush_pending);
  assign hit_event = state == IDLE && hit && !flush && !flush_pending;
  assign miss_event = state == IDLE && next_state == MEM_READ;
  assign mem.mem_read = state == MEM_READ;
  assign hit_count = hit_total;
  assign miss_count = miss_total;
  always_comb begin
    next_state = state;
    busywait = state != IDLE || !hit || flush || flush_pending;
    if (state == IDLE && !flushing && !hit) next_state = MEM_READ;
    if (state == MEM_READ && !mem.mem_busywait) next_state = UPDATE;
    if (state == UPDATE) next_state = IDLE;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      flush_pending <= 1'b0;
      mem.mem_address <= '0;
      hit_total <= '0;
      miss_total <= '0;
    end else begin
      state <= next_state;
      flush_pending <= state != IDLE && (flush_pending || flush);
      if (miss_event) mem.mem_address <= address[31:4];
      hit_total <= counter_clear ? '0 : hit_total + 32'(hit_event && hit_total != '1);
      miss_total <= counter_clear ? '0 : miss_total + 32'(miss_event && miss_total != '1);
    end
  always_ff @(posedge clock)
    if (state == MEM_READ && !mem.mem_busywait) line <= mem.mem_readdata;
endmodule

// File: tb/tb_instruction_cache.sv
// tb_instruction_cache: directed and random fetches checked against an array-based cache model.
module tb_instruction_cache;
  logic clock = 1'b0, reset, flush, counter_clear, busywait;
  logic [31:0] address, instruction, hit_count, miss_count;
  int checks = 0, errors = 0, lat = 1, mcnt = 0;
  bit mv [8];
  logic [24:0] mt [8];
  logic [31:0] m_hit, m_miss;
  instruction_cache_if mbus();
  instruction_cache dut (
    .clock, .reset, .address, .instruction, .busywait, .flush, .counter_clear,
    .mem(mbus), .hit_count, .miss_count
  );
  always #5 clock = ~clock;
  function automatic logic [31:0] mem_word(input logic [27:0] ln, input logic [1:0] w);
    if (ln == 28'd0) return w == 2'd0 ? 32'h00A00093 : 32'h00000013;
    return {ln[23:0], 6'b0, w} ^ 32'hA5000000;
  endfunction
  function automatic logic [31:0] sat(input logic [31:0] v);
    return v == '1 ? v : v + 1;
  endfunction
  always_ff @(posedge clock) mcnt <= mbus.mem_read ? mcnt + 1 : 0;
  assign mbus.mem_busywait = mbus.mem_read && mcnt < lat;
  assign mbus.mem_readdata = {mem_word(mbus.mem_address, 2'd3), mem_word(mbus.mem_address, 2'd2),
                              mem_word(mbus.mem_address, 2'd1), mem_word(mbus.mem_address, 2'd0)};
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_counters();
    check("hit_count", hit_count, m_hit);
    check("miss_count", miss_count, m_miss);
  endtask
  task automatic fetch(input logic [31:0] a, input int l);
    int stalls = 0;
    int idx = int'(a[6:4]);
    bit exp_hit = mv[idx] && mt[idx] == a[31:7];
    lat = l;
    address = a;
    @(negedge clock);
    while (busywait && stalls < 200) begin
      if (mbus.mem_read) check("mem_address", 32'(mbus.mem_address), 32'(a[31:4]));
      stalls++;
      @(negedge clock);
    end
    check("stalls", stalls, exp_hit ? 0 : l + 3);
    check("instruction", instruction, mem_word(a[31:4], a[3:2]));
    check("mem_read_idle", 32'(mbus.mem_read), 0);
    if (!exp_hit) begin
      mv[idx] = 1'b1;
      mt[idx] = a[31:7];
      m_miss = sat(m_miss);
    end
    m_hit = sat(m_hit);
    @(posedge clock); #1;
    check_counters();
  endtask
  // flush held across one edge of the first fill; the line must be refilled afterwards
  task automatic flush_fill(input logic [31:0] a, input int l);
    int stalls = 0;
    bit flushed = 0;
    lat = l;
    address = a;
    @(negedge clock);
    while (busywait && stalls < 200) begin
      flush = mbus.mem_read && !flushed;
      if (mbus.mem_read) flushed = 1;
      stalls++;
      @(negedge clock);
    end
    flush = 1'b0;
    check("flush_stalls", stalls, 2 * (l + 3) + 1);
    check("flush_instruction", instruction, mem_word(a[31:4], a[3:2]));
    foreach (mv[i]) mv[i] = 1'b0;
    mv[a[6:4]] = 1'b1;
    mt[a[6:4]] = a[31:7];
    m_miss = sat(sat(m_miss));
    m_hit = sat(m_hit);
    @(posedge clock); #1;
    check_counters();
  endtask
  initial begin
    logic [31:0] a;
    reset = 1'b1; flush = 1'b0; counter_clear = 1'b0; address = '0;
    m_hit = '0; m_miss = '0;
    foreach (mv[i]) mv[i] = 1'b0;
    @(negedge clock);
    check("reset_busywait", 32'(busywait), 1);
    check("reset_mem_read", 32'(mbus.mem_read), 0);
    check("reset_mem_address", 32'(mbus.mem_address), 0);
    check_counters();
    @(posedge clock); #1;
    reset = 1'b0;
    fetch(32'h0, 1);
    fetch(32'h4, 0);
    fetch(32'h8, 0);
    fetch(32'hC, 0);
    fetch(32'h80, 2);
    fetch(32'h0, 1);
    check("miss3", miss_count, 3);
    flush_fill(32'h40, 2);
    fetch(32'h0, 0);
    address = 32'h0;
    flush = 1'b1;
    #1 check("flush_idle_busywait", 32'(busywait), 1);
    @(posedge clock); #1;
    flush = 1'b0;
    foreach (mv[i]) mv[i] = 1'b0;
    check_counters();
    fetch(32'h0, 1);
    lat = 5;
    address = 32'h300;
    repeat (2) @(negedge clock);
    check("pre_reset_mem_read", 32'(mbus.mem_read), 1);
    reset = 1'b1;
    #1;
    check("async_reset_mem_read", 32'(mbus.mem_read), 0);
    check("async_reset_mem_address", 32'(mbus.mem_address), 0);
    check("async_reset_busywait", 32'(busywait), 1);
    m_hit = '0; m_miss = '0;
    foreach (mv[i]) mv[i] = 1'b0;
    check_counters();
    @(posedge clock); #1;
    reset = 1'b0;
    fetch(32'h300, 1);
    fetch(32'hFFFFFFFC, 2);
    address = 32'h300;
    force dut.hit_total = 32'hFFFFFFFE;
    @(negedge clock);
    release dut.hit_total;
    repeat (2) begin
      @(posedge clock); #1;
      check("hit_saturate", hit_count, 32'hFFFFFFFF);
    end
    counter_clear = 1'b1;
    @(posedge clock); #1;
    counter_clear = 1'b0;
    m_hit = '0; m_miss = '0;
    check_counters();
    force dut.miss_total = 32'hFFFFFFFF;
    @(negedge clock);
    release dut.miss_total;
    m_miss = '1;
    @(posedge clock); #1;
    m_hit = sat(m_hit);
    fetch(32'h1230, 1);
    for (int n = 0; n < 60; n++) begin
      a = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4) | ($urandom_range(0, 3) << 2);
      if ($urandom_range(0, 9) == 0) a = a | 32'hABC00000;
      fetch(a, int'($urandom_range(0, 3)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_cache.md
Name: instruction_cache

Overview:
- Direct-mapped, read-only instruction cache feeding the fetch stage.
- Fetch presents the PC every cycle. The cache returns the addressed instruction word combinationally on a hit, or stalls fetch via busywait while it fills a line from instruction memory.
- Provides an invalidate-all port for OS-initiated context-switch flushes, plus hit/miss counters for measuring switch cost.

Parameters:
- NUM_LINES, 8, number of cache lines (power of two); index width IDX = log2(NUM_LINES).
- WORDS_PER_LINE, 4, 32-bit words per line (fixed at 4; line = 128 bits).
- TAG_W, 32-4-IDX, tag width; 25 by default.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- address  in  32  byte address (PC); bits[1:0] ignored
- instruction  out  32  selected word; valid only when busywait=0
- busywait  out  1  high while the instruction output is not valid
- flush  in  1  level; invalidate all lines
- counter_clear  in  1  synchronous clear of both counters
- mem_read  out  1  line read request to instruction memory
- mem_address  out  28  line address = address[31:4]
- mem_readdata  in  128  line data; word0 in bits[31:0]
- mem_busywait  in  1  memory busy; read data is valid in the cycle it is low while mem_read=1
- hit_count  out  32  saturating hit counter
- miss_count  out  32  saturating miss counter

Behaviour:
- Address split: offset=address[3:2], index=address[3+IDX:4], tag=address[31:4+IDX].
- Storage per line: valid bit, TAG_W tag, 128-bit data. All valid bits are cleared on reset; tags and data are not reset.
- hit = valid[index] & (tag_array[index]==tag); evaluated combinationally.
- instruction = data[index][32*offset+:32] (combinational read).
- FSM states: IDLE, MEM_READ, UPDATE.
- IDLE:
  - busywait = ~hit | flush | flush_pending.
  - On a miss with no flush: go to MEM_READ at the next edge and latch mem_address = address[31:4].
  - Hit latency is 0 cycles.
- MEM_READ:
  - mem_read=1 and busywait=1.
  - Stay while mem_busywait=1.
  - At the edge where mem_busywait=0, capture mem_readdata and go to UPDATE.
- UPDATE:
  - busywait=1 and mem_read=0.
  - At the edge, write data and tag, set valid, and go to IDLE.
  - The next cycle is a hit for the same address.
  - Minimum miss penalty is 3 cycles (IDLE detect, 1 MEM_READ, UPDATE).
- The address may change during a fill. The fill always completes using the latched mem_address, and the line written is the latched line. The hit check in IDLE then uses the current address.
- Flush:
  - Sampled every edge. If the state is not IDLE, flush_pending is set.
  - At any edge in IDLE with flush|flush_pending, all valid bits are cleared and flush_pending is cleared. No miss is started at that edge.
  - An in-flight fill completes and is then invalidated; this is the intended behaviour.
- Counters:
  - hit_count increments on each edge in IDLE with hit=1 and no flush/flush_pending.
  - miss_count increments on each IDLE->MEM_READ transition.
  - Both saturate at 0xFFFFFFFF.
  - counter_clear has priority over increment.
- Reset: state=IDLE, flush_pending=0, all valid=0, mem_read=0, mem_address=0, counters=0.
  - Reset during MEM_READ abandons the fill and drops mem_read asynchronously.
- Outputs after reset: busywait=1 unless the current address hits. Since all lines are invalid, busywait=1 whenever flush is low.
- Reset PC 0xFFFFFFFC is an ordinary miss and fills line address 0x0FFFFFFF; no special case.

Decomposition:
- Shared package holds:
  - line and word widths
  - state encoding: IDLE=2'd0, MEM_READ=2'd1, UPDATE=2'd2
  - NOP constant 32'h00000013
- Sub-module icache_storage: valid/tag/data arrays, combinational read, synchronous line write, synchronous invalidate-all.
- The FSM and counters stay in the top module.

Test Plan:
- After reset, address=0x00000000 with memory (2-cycle busywait) returning 128'h...00000013_00A00093: busywait=1 for 4 cycles, mem_read high only in MEM_READ, mem_address=0, then instruction=0x00A00093, busywait=0, miss_count=1.
- Sequential addresses 0x4, 0x8, 0xC after that fill: each hits with 0 latency, instruction = words 1..3, hit_count increments by 3, no mem_read.
- Conflict: 0x00000000 then 0x00000080 (same index 0, different tag) -> miss and refill. Returning to 0x00000000 -> miss again; miss_count=3.
- flush pulsed during MEM_READ of 0x40: fill completes, valid cleared at the next IDLE edge, and the next access to 0x40 misses.
- reset asserted mid-MEM_READ: mem_read=0 immediately and state=IDLE. After release, the same address misses again with counters at 0.
- Counter saturation: preload via long hit loop (or force) to 0xFFFFFFFF -> stays at 0xFFFFFFFF. counter_clear together with a hit -> 0.
